tx_burst_ctrl: RTL and testbench
================================

Name: tx_burst_ctrl

Overview:
Sequencer for the Tx symbol datapath (prbs31 -> grey_encode -> pam_4_encode). On a start request it sends a fixed training preamble of PAM-4 symbols, then gates the PRBS to deliver exactly burst_len grey-coded payload symbols. It then flushes and reports completion. It sits between grey_encode and pam_4_encode, drives the prbs31 enable, and muxes preamble and payload symbols onto a single symbol stream.

Parameters:
BURST_W, 16, width of burst_len and sym_count
PREAMBLE_LEN, 16, number of preamble symbols (>=2, even)
FLUSH_CYCLES, 8, idle cycles after payload before done (>=1)
PREAMBLE_A, 2'b11, preamble symbol in even slots
PREAMBLE_B, 2'b00, preamble symbol in odd slots

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle burst request
abort  in  1  abandon current burst
burst_len  in  BURST_W  payload symbol count, sampled with start
prbs_en  out  1  enable to prbs31
sym_in  in  2  symbol from grey_encode
sym_in_valid  in  1  sym_in qualifier
symbol_out  out  2  symbol to pam_4_encode
symbol_out_valid  out  1  symbol_out qualifier
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
sym_count  out  BURST_W  payload symbols forwarded in the current burst

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE.
  - prbs_en, symbol_out_valid, busy and done = 0.
  - symbol_out = 2'b00, sym_count = 0.
  - Internal counters are cleared.
- All outputs are registered.
- States: IDLE, PREAMBLE, PAYLOAD, FLUSH, DONE.
- IDLE:
  - start=1 latches burst_len, clears sym_count and goes to PREAMBLE.
  - start is ignored in every other state.
- PREAMBLE:
  - Outputs PREAMBLE_LEN consecutive valid symbols, alternating PREAMBLE_A and PREAMBLE_B, starting with A.
  - The first symbol appears in the cycle after start is sampled.
  - After the last preamble symbol: go to PAYLOAD if the latched length is nonzero, otherwise go to FLUSH.
- PAYLOAD:
  - prbs_en=1 from the first PAYLOAD cycle.
  - Each sym_in_valid=1 is forwarded: symbol_out=sym_in and symbol_out_valid=1 one cycle later, and sym_count increments.
  - symbol_out_valid=0 in cycles without input (pipeline fill gaps are legal).
  - When the forwarded count reaches the latched length: prbs_en=0 in the next cycle and go to FLUSH.
- FLUSH:
  - Any sym_in_valid arriving here is discarded. These are PRBS bits already in flight and are not forwarded.
  - symbol_out_valid=0.
  - Stay FLUSH_CYCLES cycles, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the IDLE cycle.
- abort=1 in any non-IDLE state:
  - Next cycle: state=IDLE, prbs_en=0, symbol_out_valid=0, no done pulse.
  - sym_count holds its value.
  - abort has priority over every transition.
- start and abort asserted together in IDLE: abort wins; stay IDLE.
- sym_count saturates at burst_len and never wraps.
- burst_len = 2^BURST_W-1 is legal.
- Reset asserted mid-burst: immediate return to the reset values, with prbs_en low asynchronously.

Optional Feature:
TX_BURST_POSTAMBLE_EN:
- Defined: a POSTAMBLE state between PAYLOAD and FLUSH (also entered for zero-length bursts) emits PREAMBLE_LEN valid symbols of constant 2'b01. In-flight sym_in is discarded during POSTAMBLE.
- Undefined: the state and its logic are absent; PAYLOAD goes directly to FLUSH.

Decomposition:
- Shared package/header tx_ctrl_pkg holds:
  - state encodings;
  - symbol constants 2'b00, 2'b01, 2'b11;
  - the default PREAMBLE_LEN and FLUSH_CYCLES.
- One natural sub-module, tx_pattern_gen: a counter-driven generator of the alternating or constant pattern with a done flag. It is reused by PREAMBLE and POSTAMBLE.

Test Plan:
- Reset then start with burst_len=4, sym_in_valid every cycle:
  - 16 preamble symbols 11,00,11,00,...;
  - then 4 forwarded symbols equal to sym_in delayed 1 cycle;
  - sym_count=4, then 8 flush cycles, done pulse, busy=0.
- burst_len=0 -> 16 preamble symbols, prbs_en never 1, done 8+1 cycles after the last preamble symbol.
- burst_len=3 with sym_in_valid pattern 1,0,0,1,1,1 -> exactly 3 outputs, gaps preserved, the 4th input discarded, prbs_en low after the 3rd.
- abort in cycle 5 of PAYLOAD -> IDLE next cycle, prbs_en=0, no done, sym_count holds its value.
- start pulsed while busy -> ignored; the burst completes with its original length.
- rstn low mid-PAYLOAD -> all outputs zero immediately; a new start after release behaves as in the first scenario.

Source files
------------

// File: rtl/tx_ctrl_pkg.sv
// tx_ctrl_pkg: state encodings, symbol constants and defaults for the Tx
// burst sequencer. S_POST exists only when TX_BURST_POSTAMBLE_EN is defined.
package tx_ctrl_pkg;

  localparam logic [1:0] SYM_00 = 2'b00;
  localparam logic [1:0] SYM_01 = 2'b01;
  localparam logic [1:0] SYM_11 = 2'b11;

  localparam int DEF_PREAMBLE_LEN = 16;
  localparam int DEF_FLUSH_CYCLES = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_PAY   = 3'd2,
`ifdef TX_BURST_POSTAMBLE_EN
    S_POST  = 3'd3,
`endif
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/tx_burst_ctrl_if.sv
// tx_burst_ctrl_if: symbol stream between grey_encode, the sequencer and
// pam_4_encode, plus the prbs31 enable. master = sequencer side.
interface tx_burst_ctrl_if;

  logic       prbs_en;
  logic [1:0] sym_in;
  logic       sym_in_valid;
  logic [1:0] symbol_out;
  logic       symbol_out_valid;

  modport master (
    output prbs_en,
    output symbol_out,
    output symbol_out_valid,
    input  sym_in,
    input  sym_in_valid
  );

  modport slave (
    input  prbs_en,
    input  symbol_out,
    input  symbol_out_valid,
    output sym_in,
    output sym_in_valid
  );

endinterface

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: counter-driven training pattern source. Ports: step
// advances (else clears), alt picks A/B alternation vs constant 01,
// sym is the pattern at the current index, fin flags LEN symbols emitted.
module tx_pattern_gen
  import tx_ctrl_pkg::*;
#(
  parameter int         LEN   = DEF_PREAMBLE_LEN,
  parameter logic [1:0] PAT_A = SYM_11,
  parameter logic [1:0] PAT_B = SYM_00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       step,
  input  logic       alt,
  output logic [1:0] sym,
  output logic       fin
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] cnt;

  // Idle cycles park the counter at zero so the next run starts on A.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      cnt <= step ? cnt + 1'b1 : '0;
    end
  end

  assign sym = alt ? (cnt[0] ? PAT_B : PAT_A) : SYM_01;
  assign fin = (cnt == CW'(LEN));

endmodule

// File: rtl/tx_burst_ctrl.sv
// tx_burst_ctrl: preamble / gated-PRBS payload / flush sequencer feeding
// pam_4_encode. Ports: clk, rstn, start, abort, burst_len, busy, done,
// sym_count, sif (symbol stream + prbs_en). Optional TX_BURST_POSTAMBLE_EN
// adds a constant-01 postamble between payload and flush.
module tx_burst_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int         BURST_W      = 16,
  parameter int         PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter int         FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter logic [1:0] PREAMBLE_A   = SYM_11,
  parameter logic [1:0] PREAMBLE_B   = SYM_00
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               abort,
  input  logic [BURST_W-1:0] burst_len,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] sym_count,
  tx_burst_ctrl_if.master    sif
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

`ifdef TX_BURST_POSTAMBLE_EN
  localparam state_e S_TAIL = S_POST;
`else
  localparam state_e S_TAIL = S_FLUSH;
`endif

  state_e             state;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] cnt_nxt;
  logic [FW-1:0]      fcnt;
  logic               prbs_q;
  logic               vld_q;
  logic [1:0]         sym_q;
  logic               pg_run;
  logic               pg_step;
  logic               pg_alt;
  logic               pg_fin;
  logic [1:0]         pg_sym;
  logic               pay_last;

  assign sif.prbs_en          = prbs_q;
  assign sif.symbol_out       = sym_q;
  assign sif.symbol_out_valid = vld_q;

  assign cnt_nxt  = sym_count + 1'b1;
  assign pay_last = (state == S_PAY) && sif.sym_in_valid
                  && (cnt_nxt == len);

`ifdef TX_BURST_POSTAMBLE_EN
  assign pg_run = (state == S_PRE) || (state == S_POST);
`else
  assign pg_run = (state == S_PRE);
`endif

  // The first pattern symbol leaves on the start edge itself.
  assign pg_step = !abort
                 && ((state == S_IDLE && start) || (pg_run && !pg_fin));
  assign pg_alt  = (state == S_IDLE) || (state == S_PRE);

  tx_pattern_gen #(
    .LEN   (PREAMBLE_LEN),
    .PAT_A (PREAMBLE_A),
    .PAT_B (PREAMBLE_B)
  ) u_pat (
    .clk  (clk),
    .rstn (rstn),
    .step (pg_step),
    .alt  (pg_alt),
    .sym  (pg_sym),
    .fin  (pg_fin)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      len       <= '0;
      fcnt      <= '0;
      sym_count <= '0;
      prbs_q    <= 1'b0;
      vld_q     <= 1'b0;
      sym_q     <= SYM_00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      vld_q <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        prbs_q <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              len       <= burst_len;
              sym_count <= '0;
              busy      <= 1'b1;
              state     <= S_PRE;
              sym_q     <= pg_sym;
              vld_q     <= 1'b1;
            end
          end
          S_PRE: begin
            if (!pg_fin) begin
              sym_q <= pg_sym;
              vld_q <= 1'b1;
            end else if (len != '0) begin
              state  <= S_PAY;
              prbs_q <= 1'b1;
            end else begin
              state <= S_TAIL;
              fcnt  <= '0;
            end
          end
          S_PAY: begin
            if (sif.sym_in_valid) begin
              sym_q     <= sif.sym_in;
              vld_q     <= 1'b1;
              sym_count <= cnt_nxt;
              if (pay_last) begin
                prbs_q <= 1'b0;
                state  <= S_TAIL;
                fcnt   <= '0;
              end
            end
          end
`ifdef TX_BURST_POSTAMBLE_EN
          S_POST: begin
            if (!pg_fin) begin
              sym_q <= pg_sym;
              vld_q <= 1'b1;
            end else begin
              state <= S_FLUSH;
              fcnt  <= '0;
            end
          end
`endif
          S_FLUSH: begin
            if (fcnt == FW'(FLUSH_CYCLES - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// tb_tx_burst_ctrl: directed and random bursts against an offset-based
// reference model, compared every cycle, plus literal timing anchors.
module tb_tx_burst_ctrl;

  localparam int BW = 16;
  localparam int L  = 16;
  localparam int F  = 8;

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic          busy;
  logic          done;
  logic [BW-1:0] sym_count;

  tx_burst_ctrl_if sif();

  tx_burst_ctrl #(
    .BURST_W      (BW),
    .PREAMBLE_LEN (L),
    .FLUSH_CYCLES (F),
    .PREAMBLE_A   (2'b11),
    .PREAMBLE_B   (2'b00)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .burst_len (burst_len),
    .busy      (busy),
    .done      (done),
    .sym_count (sym_count),
    .sif       (sif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position k counts edges since the accepted start;
  // fe is the edge index where the payload phase ended (-1 while open).
  bit         m_act = 0;
  int         k, m_len, fwd, fe;
  int         e_cnt = 0;
  bit         e_vld, e_prbs, e_done;
  logic [1:0] e_sym;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_act = 0;
      e_cnt = 0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_prbs", sif.prbs_en, 0);
      chk("rst_valid", sif.symbol_out_valid, 0);
      chk("rst_symbol", sif.symbol_out, 0);
      chk("rst_count", sym_count, 0);
    end else begin
      e_vld  = 0;
      e_prbs = 0;
      e_done = 0;
      if (!m_act) begin
        if (start && !abort) begin
          m_act = 1;
          k     = 0;
          m_len = int'(burst_len);
          fwd   = 0;
          fe    = -1;
          e_cnt = 0;
        end
      end else if (abort) begin
        m_act = 0;
      end else begin
        k++;
      end
      if (m_act) begin
        if (k < L) begin
          e_vld = 1;
          e_sym = (k % 2 == 0) ? 2'b11 : 2'b00;
        end else if (fe < 0) begin
          if (m_len == 0) begin
            fe = k;
          end else begin
            if (k > L && sif.sym_in_valid) begin
              e_vld = 1;
              e_sym = sif.sym_in;
              fwd++;
              e_cnt = fwd;
              if (fwd == m_len) fe = k;
            end
            e_prbs = (fe < 0);
          end
        end
        if (fe >= 0 && k == fe + F) e_done = 1;
        if (fe >= 0 && k == fe + F + 1) m_act = 0;
      end
      #1;
      chk("busy", busy, m_act);
      chk("done", done, e_done);
      chk("prbs_en", sif.prbs_en, e_prbs);
      chk("valid", sif.symbol_out_valid, e_vld);
      if (e_vld) chk("symbol", sif.symbol_out, e_sym);
      chk("sym_count", sym_count, e_cnt);
    end
  end

  int vmode = 1;
  bit rmode = 0;
  bit vq[$];

  task automatic step();
    @(negedge clk);
    sif.sym_in = 2'($urandom);
    if (vq.size() > 0) sif.sym_in_valid = vq.pop_front();
    else if (vmode == 1) sif.sym_in_valid = 1'b1;
    else if (vmode == 0) sif.sym_in_valid = ($urandom_range(0, 9) < 7);
    else sif.sym_in_valid = 1'b0;
    if (rmode) begin
      start     = ($urandom_range(0, 39) == 0);
      abort     = ($urandom_range(0, 299) == 0);
      burst_len = BW'($urandom_range(0, 40));
    end
  endtask

  task automatic pulse_start(input int n);
    step();
    start     = 1'b1;
    burst_len = BW'(n);
    step();
    start     = 1'b0;
  endtask

  task automatic run_to_done(input int k0, input int maxc,
                             output int kd, output int nv, output bit sp);
    kd = -1;
    nv = 0;
    sp = 0;
    for (int i = 0; i < maxc; i++) begin
      nv += int'(sif.symbol_out_valid);
      sp |= sif.prbs_en;
      if (done) begin
        kd = k0 + i;
        break;
      end
      step();
    end
    if (kd < 0) chk("done_timeout", 0, 1);
  endtask

  int kd, nv;
  bit sp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.sym_in       = 2'b00;
    sif.sym_in_valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();

    // Burst of 4 with a symbol every cycle.
    vmode = 1;
    pulse_start(4);
    chk("s1_first_sym", sif.symbol_out, 2'b11);
    chk("s1_first_vld", sif.symbol_out_valid, 1);
    step();
    chk("s1_second_sym", sif.symbol_out, 2'b00);
    run_to_done(1, 200, kd, nv, sp);
    chk("s1_done_k", kd, 28);
    chk("s1_count", sym_count, 4);
    step();
    chk("s1_idle_busy", busy, 0);

    // Zero-length burst.
    pulse_start(0);
    run_to_done(0, 200, kd, nv, sp);
    chk("s2_done_k", kd, 24);
    chk("s2_prbs_seen", sp, 0);
    chk("s2_nvalid", nv, 16);
    step();

    // Length 3 with gaps; 4th input arrives after the end and is dropped.
    vmode = 2;
    repeat (L + 1) vq.push_back(1'b0);
    vq.push_back(1'b1);
    vq.push_back(1'b0);
    vq.push_back(1'b0);
    vq.push_back(1'b1);
    vq.push_back(1'b1);
    vq.push_back(1'b1);
    pulse_start(3);
    run_to_done(0, 200, kd, nv, sp);
    chk("s3_done_k", kd, 29);
    chk("s3_nvalid", nv, 19);
    chk("s3_count", sym_count, 3);
    step();

    // Abort in the 5th payload cycle.
    vmode = 1;
    pulse_start(10);
    repeat (L + 4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("s4_busy", busy, 0);
    chk("s4_prbs", sif.prbs_en, 0);
    chk("s4_count", sym_count, 4);
    sp = 0;
    for (int i = 0; i < 40; i++) begin
      sp |= done;
      step();
    end
    chk("s4_no_done", sp, 0);

    // Start pulses while busy are ignored.
    pulse_start(5);
    repeat (3) step();
    start     = 1'b1;
    burst_len = BW'(9);
    step();
    start = 1'b0;
    repeat (16) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done(0, 200, kd, nv, sp);
    chk("s5_count", sym_count, 5);
    step();

    // Start with abort in idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("s7_busy", busy, 0);
    step();

    // Reset mid-payload, then a clean burst.
    pulse_start(6);
    repeat (L + 3) step();
    chk("s6_prbs_before", sif.prbs_en, 1);
    #2 rstn = 1'b0;
    #1;
    chk("s6_rst_prbs", sif.prbs_en, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_count", sym_count, 0);
    step();
    step();
    rstn = 1'b1;
    step();
    pulse_start(4);
    run_to_done(0, 200, kd, nv, sp);
    chk("s6_done_k", kd, 28);
    chk("s6_count", sym_count, 4);
    step();

    // Random starts, aborts, lengths and valid patterns.
    vmode = 0;
    rmode = 1;
    repeat (3000) step();
    rmode = 0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 300 && busy; i++) step();
    chk("rand_drain", busy, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
